// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-port APB arbiter in front of the SPI/XIP controller.
// Address-map defaults, port ids, FSM state enum and the address-legality helper.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } spi_arb_state_e;

    localparam logic [31:0] FLASH_BASE_DEF = 32'h3000_0000;
    localparam logic [31:0] FLASH_END_DEF  = 32'h3fff_ffff;
    localparam logic [31:0] SPI_BASE_DEF   = 32'h1000_1000;
    localparam logic [31:0] SPI_END_DEF    = 32'h1000_1fff;

    localparam logic PORT_IFU = 1'b0;
    localparam logic PORT_LSU = 1'b1;

    // Flash window is read-only; the SPI register window accepts reads and writes.
    function automatic logic addr_legal(
        input logic [31:0] addr,
        input logic        write,
        input logic [31:0] flash_base,
        input logic [31:0] flash_end,
        input logic [31:0] spi_base,
        input logic [31:0] spi_end
    );
        return (!write && addr >= flash_base && addr <= flash_end) ||
               (addr >= spi_base && addr <= spi_end);
    endfunction

endpackage

// File: rtl/spi_arb_rr_picker.sv
// Combinational 2-way picker: single requester wins outright; a tie goes to the port
// that was not served last (round-robin) or to the IFU port (fixed priority).
module spi_arb_rr_picker
    import spi_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    input  logic       rr_en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_id_o = PORT_IFU;
        case (req_i)
            2'b10:   gnt_id_o = PORT_LSU;
            2'b11:   gnt_id_o = rr_en_i ? ~rr_last_i : PORT_IFU;
            default: gnt_id_o = PORT_IFU;
        endcase
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/spi_apb_arbiter.sv
// Two-port APB arbiter sharing the spi_top_apb slave port; replays the granted transfer
// as a clean SETUP/ACCESS pair. Optional ACCESS watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_apb_arbiter
    import spi_arb_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE    = FLASH_BASE_DEF,
    parameter logic [31:0] FLASH_END     = FLASH_END_DEF,
    parameter logic [31:0] SPI_BASE      = SPI_BASE_DEF,
    parameter logic [31:0] SPI_END       = SPI_END_DEF,
    parameter bit          RR_EN_DEFAULT = 1'b1
`ifdef SPI_ARB_TIMEOUT_EN
    , parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
`endif
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [31:0]    s0_paddr,
    input  logic           s0_psel,
    input  logic           s0_penable,
    input  logic           s0_pwrite,
    input  logic [31:0]    s0_pwdata,
    input  logic [3:0]     s0_pstrb,
    input  logic [2:0]     s0_pprot,
    output logic           s0_pready,
    output logic [31:0]    s0_prdata,
    output logic           s0_pslverr,
    input  logic [31:0]    s1_paddr,
    input  logic           s1_psel,
    input  logic           s1_penable,
    input  logic           s1_pwrite,
    input  logic [31:0]    s1_pwdata,
    input  logic [3:0]     s1_pstrb,
    input  logic [2:0]     s1_pprot,
    output logic           s1_pready,
    output logic [31:0]    s1_prdata,
    output logic           s1_pslverr,
    output logic [31:0]    m_paddr,
    output logic           m_psel,
    output logic           m_penable,
    output logic           m_pwrite,
    output logic [31:0]    m_pwdata,
    output logic [3:0]     m_pstrb,
    output logic [2:0]     m_pprot,
    input  logic           m_pready,
    input  logic [31:0]    m_prdata,
    input  logic           m_pslverr,
    output logic           grant_id,
    output logic           busy,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic           timeout_flag,
`endif
    output spi_arb_state_e dbg_state
);

    // Requesters assert penable per APB, but only psel marks a request here.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    spi_arb_state_e state_q;
    logic        gid_q, rr_last_q, drop_q;
    logic        m_psel_q, m_penable_q, m_pwrite_q;
    logic [31:0] m_paddr_q, m_pwdata_q;
    logic [3:0]  m_pstrb_q;
    logic [2:0]  m_pprot_q;
    logic        s0_pready_q, s0_pslverr_q, s1_pready_q, s1_pslverr_q;
    logic [31:0] s0_prdata_q, s1_prdata_q;

    logic [1:0]  req, gnt;
    logic        pick_id, gnt_psel, sel_pwrite, sel_legal;
    logic [31:0] sel_paddr, sel_pwdata;
    logic [3:0]  sel_pstrb;
    logic [2:0]  sel_pprot;
    logic        resp_fire, resp_port, resp_err, access_done;
    logic [31:0] resp_data;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        to_flag_q, to_hit;
    assign to_hit       = (state_q == ACCESS) && !m_pready && (to_cnt_q == TIMEOUT_CYCLES - 16'd1);
    assign timeout_flag = to_flag_q;
`else
    logic to_hit;
    assign to_hit = 1'b0;
`endif

    assign req = {s1_psel, s0_psel};

    spi_arb_rr_picker u_picker (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .rr_en_i   (RR_EN_DEFAULT),
        .gnt_o     (gnt),
        .gnt_id_o  (pick_id)
    );

    always_comb begin
        sel_paddr   = gnt[1] ? s1_paddr  : s0_paddr;
        sel_pwrite  = gnt[1] ? s1_pwrite : s0_pwrite;
        sel_pwdata  = gnt[1] ? s1_pwdata : s0_pwdata;
        sel_pstrb   = gnt[1] ? s1_pstrb  : s0_pstrb;
        sel_pprot   = gnt[1] ? s1_pprot  : s0_pprot;
        sel_legal   = addr_legal(sel_paddr, sel_pwrite, FLASH_BASE, FLASH_END, SPI_BASE, SPI_END);
        gnt_psel    = gid_q ? s1_psel : s0_psel;
        access_done = (state_q == ACCESS) && (m_pready || to_hit);
        resp_fire   = 1'b0;
        resp_port   = gid_q;
        resp_data   = 32'h0;
        resp_err    = 1'b0;
        if (state_q == IDLE && (|gnt) && !sel_legal) begin
            resp_fire = 1'b1;
            resp_port = pick_id;
            resp_err  = 1'b1;
        end else if (access_done) begin
            // A requester that let go of psel mid-transfer gets no response.
            resp_fire = !drop_q && gnt_psel;
            resp_data = m_pready ? m_prdata : 32'h0;
            resp_err  = m_pready ? m_pslverr : 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gid_q        <= PORT_IFU;
            rr_last_q    <= PORT_LSU;
            drop_q       <= 1'b0;
            m_psel_q     <= 1'b0;
            m_penable_q  <= 1'b0;
            m_pwrite_q   <= 1'b0;
            m_paddr_q    <= 32'h0;
            m_pwdata_q   <= 32'h0;
            m_pstrb_q    <= 4'h0;
            m_pprot_q    <= 3'h0;
            s0_pready_q  <= 1'b0;
            s0_prdata_q  <= 32'h0;
            s0_pslverr_q <= 1'b0;
            s1_pready_q  <= 1'b0;
            s1_prdata_q  <= 32'h0;
            s1_pslverr_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q     <= 16'h0;
            to_flag_q    <= 1'b0;
`endif
        end else begin
            s0_pready_q  <= 1'b0;
            s0_prdata_q  <= 32'h0;
            s0_pslverr_q <= 1'b0;
            s1_pready_q  <= 1'b0;
            s1_prdata_q  <= 32'h0;
            s1_pslverr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        gid_q      <= pick_id;
                        drop_q     <= 1'b0;
                        m_paddr_q  <= sel_paddr;
                        m_pwrite_q <= sel_pwrite;
                        m_pwdata_q <= sel_pwdata;
                        m_pstrb_q  <= sel_pstrb;
                        m_pprot_q  <= sel_pprot;
                        if (sel_legal) begin
                            state_q  <= SETUP;
                            m_psel_q <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                            to_cnt_q <= 16'h0;
`endif
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                SETUP: begin
                    if (!gnt_psel) drop_q <= 1'b1;
                    m_penable_q <= 1'b1;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    if (!gnt_psel) drop_q <= 1'b1;
                    if (access_done) begin
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        state_q     <= RESP;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    if (to_hit) to_flag_q <= 1'b1;
                    to_cnt_q <= to_cnt_q + 16'd1;
`endif
                end
                RESP: begin
                    rr_last_q <= gid_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (resp_fire) begin
                if (resp_port) begin
                    s1_pready_q  <= 1'b1;
                    s1_prdata_q  <= resp_data;
                    s1_pslverr_q <= resp_err;
                end else begin
                    s0_pready_q  <= 1'b1;
                    s0_prdata_q  <= resp_data;
                    s0_pslverr_q <= resp_err;
                end
            end
        end
    end

    assign s0_pready  = s0_pready_q;
    assign s0_prdata  = s0_prdata_q;
    assign s0_pslverr = s0_pslverr_q;
    assign s1_pready  = s1_pready_q;
    assign s1_prdata  = s1_prdata_q;
    assign s1_pslverr = s1_pslverr_q;
    assign m_paddr    = m_paddr_q;
    assign m_psel     = m_psel_q;
    assign m_penable  = m_penable_q;
    assign m_pwrite   = m_pwrite_q;
    assign m_pwdata   = m_pwdata_q;
    assign m_pstrb    = m_pstrb_q;
    assign m_pprot    = m_pprot_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Directed bench for spi_apb_arbiter: arbitration, address checks, error/latency paths,
// abandoned transfers, async reset, and the watchdog when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_apb_arbiter;
  import spi_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] s0_paddr, s0_pwdata, s0_prdata, s1_paddr, s1_pwdata, s1_prdata;
  logic        s0_psel, s0_penable, s0_pwrite, s0_pready, s0_pslverr;
  logic        s1_psel, s1_penable, s1_pwrite, s1_pready, s1_pslverr;
  logic [3:0]  s0_pstrb, s1_pstrb, m_pstrb;
  logic [2:0]  s0_pprot, s1_pprot, m_pprot;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic        grant_id, busy;
  spi_arb_state_e dbg_state;
`ifdef SPI_ARB_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

`ifdef SPI_ARB_TIMEOUT_EN
  spi_apb_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clock(clock), .reset(reset),
    .s0_paddr(s0_paddr), .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
    .s0_pwdata(s0_pwdata), .s0_pstrb(s0_pstrb), .s0_pprot(s0_pprot),
    .s0_pready(s0_pready), .s0_prdata(s0_prdata), .s0_pslverr(s0_pslverr),
    .s1_paddr(s1_paddr), .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
    .s1_pwdata(s1_pwdata), .s1_pstrb(s1_pstrb), .s1_pprot(s1_pprot),
    .s1_pready(s1_pready), .s1_prdata(s1_prdata), .s1_pslverr(s1_pslverr),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .grant_id(grant_id), .busy(busy),
    .timeout_flag(timeout_flag),
    .dbg_state(dbg_state)
  );
`else
  spi_apb_arbiter dut (
    .clock(clock), .reset(reset),
    .s0_paddr(s0_paddr), .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
    .s0_pwdata(s0_pwdata), .s0_pstrb(s0_pstrb), .s0_pprot(s0_pprot),
    .s0_pready(s0_pready), .s0_prdata(s0_prdata), .s0_pslverr(s0_pslverr),
    .s1_paddr(s1_paddr), .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
    .s1_pwdata(s1_pwdata), .s1_pstrb(s1_pstrb), .s1_pprot(s1_pprot),
    .s1_pready(s1_pready), .s1_prdata(s1_prdata), .s1_pslverr(s1_pslverr),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .grant_id(grant_id), .busy(busy),
    .dbg_state(dbg_state)
  );
`endif

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input spi_arb_state_e exp);
    chk32(tag, 32'(dbg_state), 32'(exp));
  endtask

  task automatic req(input int port, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    if (port == 0) begin
      s0_paddr = addr; s0_pwrite = wr; s0_pwdata = wdata; s0_pstrb = strb; s0_pprot = prot;
      s0_psel = 1'b1; s0_penable = 1'b1;
    end else begin
      s1_paddr = addr; s1_pwrite = wr; s1_pwdata = wdata; s1_pstrb = strb; s1_pprot = prot;
      s1_psel = 1'b1; s1_penable = 1'b1;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) begin
      s0_psel = 1'b0; s0_penable = 1'b0;
    end else begin
      s1_psel = 1'b0; s1_penable = 1'b0;
    end
  endtask

  task automatic slave_ack(input logic [31:0] data, input logic err);
    m_pready = 1'b1; m_prdata = data; m_pslverr = err;
    exp_q.push_back(data);
  endtask

  task automatic slave_idle();
    m_pready = 1'b0; m_prdata = 32'h0; m_pslverr = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk32(tag, obs, e);
    end
  endtask

  initial begin
    reset = 1'b0;
    s0_paddr = 0; s0_psel = 0; s0_penable = 0; s0_pwrite = 0; s0_pwdata = 0; s0_pstrb = 0; s0_pprot = 0;
    s1_paddr = 0; s1_psel = 0; s1_penable = 0; s1_pwrite = 0; s1_pwdata = 0; s1_pstrb = 0; s1_pprot = 0;
    slave_idle();
    tick(); tick();
    chk1("rst_m_psel", m_psel, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_grant", grant_id, 1'b0);
    chk1("rst_s0_pready", s0_pready, 1'b0);
    chk32("rst_m_paddr", m_paddr, 32'h0);
    chk_state("rst_state", IDLE);
    reset = 1'b1;

    // Port 0 flash read, slave ready on the second ACCESS cycle
    req(0, 32'h3000_0010, 1'b0, 32'h0, 4'h0, 3'b101);
    tick();
    chk_state("t1_setup", SETUP);
    chk1("t1_m_psel", m_psel, 1'b1);
    chk1("t1_m_penable_setup", m_penable, 1'b0);
    chk32("t1_m_paddr", m_paddr, 32'h3000_0010);
    chk32("t1_m_pprot", {29'h0, m_pprot}, 32'h5);
    chk1("t1_busy", busy, 1'b1);
    tick();
    chk1("t1_m_penable_access", m_penable, 1'b1);
    chk1("t1_s0_pready_early", s0_pready, 1'b0);
    tick();
    chk_state("t1_access2", ACCESS);
    slave_ack(32'h1234_5678, 1'b0);
    tick();
    chk1("t1_s0_pready", s0_pready, 1'b1);
    chk_rd("t1_s0_prdata", s0_prdata);
    chk1("t1_s0_pslverr", s0_pslverr, 1'b0);
    chk1("t1_s1_pready", s1_pready, 1'b0);
    chk1("t1_m_psel_resp", m_psel, 1'b0);
    slave_idle(); drop(0);
    tick();
    chk1("t1_idle_busy", busy, 1'b0);
    chk1("t1_pready_once", s0_pready, 1'b0);

    // Fresh reset: rr_last=1, so a tie goes to port 0 first
    reset = 1'b0; tick(); reset = 1'b1;
    req(0, 32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
    req(1, 32'h1000_1004, 1'b1, 32'hA5A5_5A5A, 4'b0110, 3'b010);
    tick();
    chk1("t2_grant0", grant_id, 1'b0);
    chk32("t2_paddr0", m_paddr, 32'h3000_0000);
    chk1("t2_pwrite0", m_pwrite, 1'b0);
    tick();
    slave_ack(32'hCAFE_F00D, 1'b0);
    tick();
    chk1("t2_s0_pready", s0_pready, 1'b1);
    chk_rd("t2_s0_prdata", s0_prdata);
    chk1("t2_s1_pready_idle", s1_pready, 1'b0);
    chk32("t2_s1_prdata_idle", s1_prdata, 32'h0);
    slave_idle(); drop(0);
    tick();
    chk1("t2_gap_busy", busy, 1'b0);
    tick();
    chk1("t2_grant1", grant_id, 1'b1);
    chk32("t2_paddr1", m_paddr, 32'h1000_1004);
    chk1("t2_pwrite1", m_pwrite, 1'b1);
    chk32("t2_pwdata1", m_pwdata, 32'hA5A5_5A5A);
    chk32("t2_pstrb1", {28'h0, m_pstrb}, 32'h6);
    tick();
    slave_ack(32'h0, 1'b0);
    tick();
    chk1("t2_s1_pready", s1_pready, 1'b1);
    chk_rd("t2_s1_prdata", s1_prdata);
    chk1("t2_s0_quiet", s0_pready, 1'b0);
    slave_idle(); drop(1);
    tick();

    // rr_last=1 again: tie goes to port 0; port 0 then keeps psel so the next tie goes to port 1
    req(0, 32'h3000_0040, 1'b0, 32'h0, 4'h0, 3'b000);
    req(1, 32'h1000_1008, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    chk1("t2_tie_again_port0", grant_id, 1'b1 ^ 1'b1);
    tick();
    slave_ack(32'h0000_00A0, 1'b0);
    tick();
    chk1("t2b_s0_pready", s0_pready, 1'b1);
    chk_rd("t2b_s0_prdata", s0_prdata);
    slave_idle();
    tick();
    tick();
    chk1("t2b_rr_port1", grant_id, 1'b1);
    chk32("t2b_paddr", m_paddr, 32'h1000_1008);
    tick();
    slave_ack(32'h0000_00B1, 1'b0);
    tick();
    chk1("t2b_s1_pready", s1_pready, 1'b1);
    chk_rd("t2b_s1_prdata", s1_prdata);
    chk1("t2b_s0_no_pready", s0_pready, 1'b0);
    slave_idle(); drop(1);
    tick();
    tick();
    chk1("t2b_held_port0", grant_id, 1'b0);
    tick();
    slave_ack(32'h1111_2222, 1'b0);
    tick();
    chk_rd("t2b_s0_prdata2", s0_prdata);
    slave_idle(); drop(0);
    tick();

    // Illegal: flash write from port 1, rejected locally in one cycle
    req(1, 32'h3000_0020, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b000);
    tick();
    chk_state("t3_state", RESP);
    chk1("t3_s1_pready", s1_pready, 1'b1);
    chk1("t3_s1_pslverr", s1_pslverr, 1'b1);
    chk32("t3_s1_prdata", s1_prdata, 32'h0);
    chk1("t3_m_psel", m_psel, 1'b0);
    chk1("t3_s0_pready", s0_pready, 1'b0);
    drop(1);
    tick();
    chk1("t3_m_psel_after", m_psel, 1'b0);

    // Illegal: unmapped read and first byte past the SPI window
    req(0, 32'h2000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    chk1("t4_s0_pready", s0_pready, 1'b1);
    chk1("t4_s0_pslverr", s0_pslverr, 1'b1);
    chk32("t4_s0_prdata", s0_prdata, 32'h0);
    chk1("t4_m_psel", m_psel, 1'b0);
    drop(0);
    tick();
    req(0, 32'h1000_2000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    chk1("t4b_spi_end_plus1_err", s0_pslverr, 1'b1);
    chk1("t4b_m_psel", m_psel, 1'b0);
    drop(0);
    tick();

    // Boundary: last flash address is legal
    req(1, 32'h3fff_ffff, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    chk_state("t5_flash_end_setup", SETUP);
    chk1("t5_m_psel", m_psel, 1'b1);
    tick();
    slave_ack(32'h0BAD_F00D, 1'b0);
    tick();
    chk_rd("t5_s1_prdata", s1_prdata);
    chk1("t5_s1_pslverr", s1_pslverr, 1'b0);
    slave_idle(); drop(1);
    tick();

    // Downstream error passes through with captured data
    req(1, 32'h1000_1010, 1'b0, 32'h0, 4'h0, 3'b000);
    tick(); tick();
    slave_ack(32'hDEAD_BEEF, 1'b1);
    tick();
    chk1("t6_s1_pready", s1_pready, 1'b1);
    chk1("t6_s1_pslverr", s1_pslverr, 1'b1);
    chk_rd("t6_s1_prdata", s1_prdata);
    slave_idle(); drop(1);
    tick();

    // Granted port abandons mid-transfer: downstream completes, no response
    req(0, 32'h3000_0100, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    drop(0);
    tick();
    chk1("t7_access_continues", m_penable, 1'b1);
    m_pready = 1'b1; m_prdata = 32'h7777_7777;
    tick();
    chk_state("t7_resp", RESP);
    chk1("t7_no_pready", s0_pready, 1'b0);
    chk32("t7_no_prdata", s0_prdata, 32'h0);
    slave_idle();
    tick();
    chk_state("t7_idle", IDLE);

    // Async reset in ACCESS drops the downstream select at once
    req(1, 32'h1000_1000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick(); tick();
    chk1("t8_in_access", m_penable, 1'b1);
    reset = 1'b0;
    #1;
    chk1("t8_async_m_psel", m_psel, 1'b0);
    chk1("t8_async_busy", busy, 1'b0);
    drop(1);
    tick();
    reset = 1'b1;
    tick();
    chk1("t8_no_resp", s1_pready, 1'b0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: slave never ready, 8 ACCESS cycles then error response
    chk1("t9_flag_clear", timeout_flag, 1'b0);
    req(0, 32'h1000_1000, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk1("t9_access_held", m_psel, 1'b1);
    end
    tick();
    chk1("t9_s0_pready", s0_pready, 1'b1);
    chk1("t9_s0_pslverr", s0_pslverr, 1'b1);
    chk32("t9_s0_prdata", s0_prdata, 32'h0);
    chk1("t9_m_psel", m_psel, 1'b0);
    chk1("t9_flag", timeout_flag, 1'b1);
    drop(0);
    tick(); tick();
    chk1("t9_flag_sticky", timeout_flag, 1'b1);
    reset = 1'b0;
    #1;
    chk1("t9_flag_reset", timeout_flag, 1'b0);
    tick();
    reset = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_apb_arbiter.md
Name: spi_apb_arbiter

Overview:
- Two-port APB arbiter sharing the single APB slave port of the SPI/XIP flash controller (spi_top_apb).
- Port 0 is the instruction-fetch path; port 1 is the data/LSU path.
- Grants one requester at a time and replays its transfer downstream as a clean APB SETUP/ACCESS pair.
- Returns the response only to the granted port; rejects illegal addresses locally, without a downstream access.

Parameters:
- FLASH_BASE, 32'h30000000, first XIP flash address (read-only window).
- FLASH_END, 32'h3fffffff, last XIP flash address.
- SPI_BASE, 32'h10001000, first SPI register address.
- SPI_END, 32'h10001fff, last SPI register address.
- RR_EN_DEFAULT, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- sN_paddr  in  32  requester address, N = 0, 1 (same set for each port).
- sN_psel, sN_penable, sN_pwrite  in  1 each  requester APB controls.
- sN_pwdata  in  32  write data.
- sN_pstrb  in  4  byte strobes.
- sN_pprot  in  3  protection bits.
- sN_pready  out  1  response strobe to requester N.
- sN_prdata  out  32  read data to requester N.
- sN_pslverr  out  1  error to requester N.
- m_paddr  out  32  to SPI controller.
- m_psel, m_penable, m_pwrite  out  1 each  to SPI controller.
- m_pwdata  out  32  to SPI controller.
- m_pstrb  out  4  to SPI controller.
- m_pprot  out  3  to SPI controller.
- m_pready  in  1  from SPI controller.
- m_prdata  in  32  from SPI controller.
- m_pslverr  in  1  from SPI controller.
- grant_id  out  1  port currently owning the bus; valid while busy.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0; rr_last=1 so port 0 wins the first tie.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE, request detection: a port requests when sN_psel=1 (penable ignored).
- IDLE, single request: that port is granted.
- IDLE, both requesting with RR: the port != rr_last is granted.
- IDLE, both requesting with fixed priority: port 0 is granted.
- IDLE, on grant: register paddr/pwrite/pwdata/pstrb/pprot; set grant_id.
- IDLE, address check: legal = read in [FLASH_BASE, FLASH_END], or read/write in [SPI_BASE, SPI_END].
- IDLE, legal request -> SETUP. Illegal request (incl. any flash write) -> RESP with err=1, rdata=0; no m_psel.
- SETUP: m_psel=1, m_penable=0 for exactly one cycle -> ACCESS.
- ACCESS: m_psel=1, m_penable=1; held until m_pready=1. Then capture m_prdata/m_pslverr, drop m_psel/m_penable -> RESP. No cycle limit.
- RESP: sN_pready=1 for exactly one cycle, on granted port only, with captured prdata/pslverr. Update rr_last=grant_id -> IDLE.
- Ungranted port: pready=0, prdata=0, pslverr=0 at all times.
- Minimum latency: request seen in IDLE at cycle t -> requester pready at t+3 (downstream pready in first ACCESS cycle).
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP, so one idle cycle separates transfers.
- A requester still holding psel in that IDLE cycle, after its own pready, is treated as a new request. Requesters must drop psel the cycle after pready.
- Granted requester drops psel mid-transfer: the downstream transfer completes; the response is discarded (no pready pulse).
- Non-granted request arriving mid-transfer: held pending; it wins the next IDLE arbitration under RR.
- Reset mid-ACCESS: m_psel drops immediately (async); no response is returned.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Enabled: adds a 16-bit watchdog, cleared on SETUP entry and incremented each ACCESS cycle.
- Timeout fires when the count reaches parameter TIMEOUT_CYCLES (default 16'd4096) with no m_pready.
- On timeout: drop m_psel/m_penable -> RESP with pslverr=1, prdata=32'h0; set sticky output timeout_flag (cleared only by reset).
- Disabled: no counter, no TIMEOUT_CYCLES parameter, no timeout_flag port; ACCESS waits indefinitely.

Decomposition:
- Package spi_arb_pkg holds: state enum (IDLE, SETUP, ACCESS, RESP); default address-map constants; port-id localparams PORT_IFU=0, PORT_LSU=1.
- One sub-module: spi_arb_rr_picker — combinational 2-way picker (req[1:0], rr_last, rr_en -> gnt, gnt_id).
- All sequencing stays in the top block.

Test Plan:
- Port 0 reads 0x30000010; slave returns pready on 2nd ACCESS cycle, prdata=0x12345678 -> s0_pready at t+4 with 0x12345678, s1_pready stays 0.
- Both ports request in same cycle after reset (s0 read 0x30000000, s1 write 0x10001004) -> port 0 served first, then port 1; next simultaneous tie goes to port 0 again (rr_last=1).
- s1 writes 0x30000020 -> s1_pready at t+1 with pslverr=1; m_psel never asserts.
- s0 reads 0x20000000 -> pslverr=1, prdata=0; no downstream access.
- Downstream m_pslverr=1 on SPI read 0x10001010 -> requester gets pslverr=1 and the captured m_prdata.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and m_pready held 0 -> pslverr=1 after 8 ACCESS cycles; timeout_flag=1 until reset=0.
